// File: rtl/memory_turn_ctrl_if.sv
// Button/board/display bundle for the card-matching turn controller.
// The master side drives buttons and the board read. The slave side is the controller.
interface memory_turn_ctrl_if #(
  parameter int unsigned NUM_CELLS   = 16,
  parameter int unsigned NUM_PLAYERS = 2,
  parameter int unsigned VAL_W       = 3,
  parameter int unsigned SCORE_W     = 4
);
  localparam int unsigned IDX_W = $clog2(NUM_CELLS);
  localparam int unsigned PL_W  = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;

  logic                           move;
  logic                           select;
  logic [VAL_W-1:0]               cell_val;
  logic [IDX_W-1:0]               cursor;
  logic [NUM_CELLS-1:0]           revealed;
  logic [NUM_CELLS-1:0]           matched;
  logic [PL_W-1:0]                cur_player;
  logic [NUM_PLAYERS*SCORE_W-1:0] scores;
  logic                           match_pulse;
  logic                           miss_pulse;
  logic                           game_over;

  modport master (
    output move, select, cell_val,
    input  cursor, revealed, matched, cur_player, scores,
           match_pulse, miss_pulse, game_over
  );

  modport slave (
    input  move, select, cell_val,
    output cursor, revealed, matched, cur_player, scores,
           match_pulse, miss_pulse, game_over
  );
endinterface

// File: rtl/memory_turn_ctrl.sv
// Cursor, two-pick selection, compare/score and turn rotation for the
// card-matching game. Button inputs are levels; actions fire on rising edges.
module memory_turn_ctrl #(
  parameter int unsigned NUM_CELLS    = 16,
  parameter int unsigned NUM_PLAYERS  = 2,
  parameter int unsigned VAL_W        = 3,
  parameter int unsigned SCORE_W      = 4,
  parameter int unsigned SHOW_CYCLES  = 4,
  parameter int unsigned TURN_TIMEOUT = 0
) (
  input  logic              clk,
  input  logic              rst,
  memory_turn_ctrl_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(NUM_CELLS);
  localparam int unsigned PL_W  = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
  localparam int unsigned SH_W  = $clog2(SHOW_CYCLES + 1);
  localparam int unsigned TO_W  = (TURN_TIMEOUT > 0) ? $clog2(TURN_TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {S_FIRST, S_SECOND, S_COMPARE, S_SHOW, S_OVER} state_t;

  state_t                         state, state_nx;
  logic                           move_q, select_q, mv_e, sel_e;
  logic [IDX_W-1:0]               cursor_q, idx_a, idx_b;
  logic [NUM_CELLS-1:0]           revealed_q, matched_q, hit_a, hit_b;
  logic [PL_W-1:0]                player_q, next_player;
  logic [NUM_PLAYERS*SCORE_W-1:0] scores_q;
  logic [SCORE_W-1:0]             cur_score;
  logic [VAL_W-1:0]               val_a, val_b;
  logic [SH_W-1:0]                show_cnt;
  logic [TO_W-1:0]                to_cnt;
  logic                           match_q, miss_q, over_q;
  logic                           picking, valid_sel, do_pick, do_step, pair_eq;
  logic                           do_match, do_miss, show_last, timeout, all_done;

  // Edge-detect history; resets high so a button held through reset is not an edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      move_q   <= 1'b1;
      select_q <= 1'b1;
    end else begin
      move_q   <= bus.move;
      select_q <= bus.select;
    end
  end

  assign mv_e  = bus.move & ~move_q;
  assign sel_e = bus.select & ~select_q;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_FIRST;
    else      state <= state_nx;
  end

  // Next-state decode
  always_comb begin
    state_nx = state;
    unique case (state)
      S_FIRST:   if (timeout) state_nx = S_FIRST;
                 else if (do_pick) state_nx = S_SECOND;
      S_SECOND:  if (do_pick) state_nx = S_COMPARE;
                 else if (timeout) state_nx = S_FIRST;
      S_COMPARE: state_nx = pair_eq ? (all_done ? S_OVER : S_FIRST) : S_SHOW;
      S_SHOW:    if (show_last) state_nx = S_FIRST;
      S_OVER:    state_nx = S_OVER;
      default:   state_nx = S_FIRST;
    endcase
  end

  // Per-state action decode feeding the datapath
  always_comb begin
    picking   = (state == S_FIRST) || (state == S_SECOND);
    valid_sel = sel_e && !matched_q[cursor_q] && !revealed_q[cursor_q];
    do_pick   = picking && valid_sel;
    // any select edge swallows a simultaneous move edge
    do_step   = picking && mv_e && !sel_e;
    pair_eq   = (val_a == val_b);
    do_match  = (state == S_COMPARE) && pair_eq;
    do_miss   = (state == S_COMPARE) && !pair_eq;
    show_last = (state == S_SHOW) && (show_cnt == SH_W'(SHOW_CYCLES - 1));
    timeout   = (TURN_TIMEOUT != 0) && picking && !do_pick &&
                (to_cnt == TO_W'(TURN_TIMEOUT - 1));
    hit_a = '0;
    hit_a[idx_a] = 1'b1;
    hit_b = '0;
    hit_b[idx_b] = 1'b1;
    all_done    = &(matched_q | hit_a | hit_b);
    cur_score   = scores_q[player_q*SCORE_W +: SCORE_W];
    next_player = (player_q == PL_W'(NUM_PLAYERS - 1)) ? '0 : player_q + 1'b1;
  end

  // Board, cursor, score and counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cursor_q   <= '0;
      revealed_q <= '0;
      matched_q  <= '0;
      player_q   <= '0;
      scores_q   <= '0;
      val_a      <= '0;
      val_b      <= '0;
      idx_a      <= '0;
      idx_b      <= '0;
      show_cnt   <= '0;
      to_cnt     <= '0;
      match_q    <= 1'b0;
      miss_q     <= 1'b0;
      over_q     <= 1'b0;
    end else begin
      if (do_step)
        cursor_q <= (cursor_q == IDX_W'(NUM_CELLS - 1)) ? '0 : cursor_q + 1'b1;
      if (do_pick) begin
        revealed_q[cursor_q] <= 1'b1;
        if (state == S_FIRST) begin
          val_a <= bus.cell_val;
          idx_a <= cursor_q;
        end else begin
          val_b <= bus.cell_val;
          idx_b <= cursor_q;
        end
      end
      if (do_match) begin
        matched_q  <= matched_q | hit_a | hit_b;
        revealed_q <= revealed_q & ~(hit_a | hit_b);
        if (cur_score != '1)
          scores_q[player_q*SCORE_W +: SCORE_W] <= cur_score + 1'b1;
      end
      if (show_last || timeout) begin
        revealed_q <= '0;
        player_q   <= next_player;
      end
      show_cnt <= (state == S_SHOW) ? show_cnt + 1'b1 : '0;
      // counter idles at zero outside the picking states, so entry to FIRST starts it clean
      to_cnt   <= (TURN_TIMEOUT != 0 && picking && !do_pick && !timeout) ? to_cnt + 1'b1 : '0;
      match_q  <= do_match;
      miss_q   <= do_miss || timeout;
      over_q   <= (state_nx == S_OVER);
    end
  end

  assign bus.cursor      = cursor_q;
  assign bus.revealed    = revealed_q;
  assign bus.matched     = matched_q;
  assign bus.cur_player  = player_q;
  assign bus.scores      = scores_q;
  assign bus.match_pulse = match_q;
  assign bus.miss_pulse  = miss_q;
  assign bus.game_over   = over_q;
endmodule
